// File: rtl/relu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// relu_ctrl_pkg
// Shared types and constants for the relu_map_ctrl streaming ReLU sequencer.
//   - Feature map geometry, element and address widths.
//   - N: number of elements in one map pass, in counter width.
//   - state_t: sequencer states (IDLE, RUN, DRAIN, DONE).
// Optional feature macro used elsewhere in this slice: RELU_CLIP_EN.
// -----------------------------------------------------------------------------
package relu_ctrl_pkg;

  localparam int FM_WIDTH   = 5;
  localparam int FM_HEIGHT  = 5;
  localparam int VALUE_SIZE = 16;
  localparam int ADDR_W     = 5;
  // One extra bit so counters can hold N itself even when N == 2**ADDR_W.
  localparam int CNT_W      = ADDR_W + 1;

  typedef logic [VALUE_SIZE-1:0] value_t;
  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  localparam cnt_t N       = cnt_t'(FM_WIDTH * FM_HEIGHT);
  localparam cnt_t N_LAST  = N - cnt_t'(1);
  localparam cnt_t CNT_ONE = cnt_t'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Linear row-major buffer address of an element index.
  function automatic addr_t cnt_to_addr(input cnt_t c);
    return c[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/relu_map_ctrl_if.sv
// -----------------------------------------------------------------------------
// relu_map_ctrl_if
// Buffer-side bus of the ReLU sequencer: a read port into the input buffer
// (data returns one cycle after rd_en) and a write port with ready
// back-pressure into the output buffer.
//   master : the sequencer (drives strobes, addresses, write data)
//   slave  : the buffers (return rd_data, drive wr_ready)
// -----------------------------------------------------------------------------
interface relu_map_ctrl_if
  import relu_ctrl_pkg::*;
();

  logic   rd_en;
  addr_t  rd_addr;
  value_t rd_data;
  logic   wr_en;
  addr_t  wr_addr;
  value_t wr_data;
  logic   wr_ready;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, wr_ready
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, wr_ready
  );

endinterface

// File: rtl/relu_elem.sv
// -----------------------------------------------------------------------------
// relu_elem
// Combinational single-element ReLU.
//   elem_i   : two's complement source element
//   clip_i   : upper clip value, unsigned (only with RELU_CLIP_EN defined)
//   result_o : 0 for negative input, else the input (clipped to clip_i when
//              RELU_CLIP_EN is defined)
//   neg_o    : source element was negative (it was zeroed)
// Optional feature macro: RELU_CLIP_EN.
// -----------------------------------------------------------------------------
module relu_elem
  import relu_ctrl_pkg::*;
(
  input  value_t elem_i,
`ifdef RELU_CLIP_EN
  input  value_t clip_i,
`endif
  output value_t result_o,
  output logic   neg_o
);

  always_comb begin
    neg_o    = elem_i[VALUE_SIZE-1];
    result_o = elem_i;
    if (neg_o) begin
      result_o = '0;
    end
`ifdef RELU_CLIP_EN
    // Element is non-negative here, so an unsigned compare is exact.
    else if (elem_i > clip_i) begin
      result_o = clip_i;
    end
`endif
  end

endmodule

// File: rtl/relu_map_ctrl.sv
// -----------------------------------------------------------------------------
// relu_map_ctrl
// Streams one FM_WIDTH x FM_HEIGHT feature map from an input buffer, through a
// per-element ReLU, into an output buffer, one element per clock, with
// write back-pressure.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : begin one pass (sampled only in IDLE)
//   clip_val  : ReLU clip level, sampled at start (only with RELU_CLIP_EN)
//   busy      : pass in progress
//   done      : one-cycle pulse after the last element is written
//   neg_count : elements zeroed in the current/last pass
//   bus       : buffer read/write bus (relu_map_ctrl_if.master)
// Timing: read issued in cycle t, data captured at the end of t+1, write
// presented in t+2. A full unstalled pass is N+3 cycles from start to done.
// Optional feature macro: RELU_CLIP_EN.
// -----------------------------------------------------------------------------
module relu_map_ctrl
  import relu_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
`ifdef RELU_CLIP_EN
  input  value_t clip_val,
`endif
  output logic   busy,
  output logic   done,
  output cnt_t   neg_count,
  relu_map_ctrl_if.master bus
);

  state_t state_q;
  logic   busy_q, done_q;
  cnt_t   rd_cnt_q, wr_cnt_q, neg_q;

  // Read in flight: rd_data is valid in the cycle this is set.
  logic   flight_q;
  addr_t  flight_addr_q;

  // One-entry skid for a read that lands while the write stage is stalled.
  logic   skid_vld_q;
  value_t skid_data_q;
  addr_t  skid_addr_q;

  // Registered write stage.
  logic   wr_en_q;
  addr_t  wr_addr_q;
  value_t wr_data_q;
  logic   wr_neg_q;

`ifdef RELU_CLIP_EN
  value_t clip_q;
`endif

  logic   stall, wr_accept, rd_fire, src_vld, src_neg;
  value_t src_data, relu_data;
  addr_t  src_addr;

  always_comb begin
    stall     = wr_en_q && !bus.wr_ready;
    wr_accept = wr_en_q && bus.wr_ready;
    // Gated by the live stall so no read is ever issued while the write
    // stage holds; this bounds in-flight data to the single skid entry.
    rd_fire   = (state_q == RUN) && (rd_cnt_q < N) && !stall;
    // Skid data is older than anything arriving, so it goes first.
    src_vld   = skid_vld_q || flight_q;
    src_data  = skid_vld_q ? skid_data_q : bus.rd_data;
    src_addr  = skid_vld_q ? skid_addr_q : flight_addr_q;
  end

  relu_elem u_elem (
    .elem_i   (src_data),
`ifdef RELU_CLIP_EN
    .clip_i   (clip_q),
`endif
    .result_o (relu_data),
    .neg_o    (src_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      neg_q         <= '0;
      flight_q      <= 1'b0;
      flight_addr_q <= '0;
      skid_vld_q    <= 1'b0;
      skid_data_q   <= '0;
      skid_addr_q   <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_neg_q      <= 1'b0;
`ifdef RELU_CLIP_EN
      clip_q        <= '0;
`endif
    end else begin
      done_q        <= 1'b0;
      flight_q      <= rd_fire;
      flight_addr_q <= cnt_to_addr(rd_cnt_q);

      if (rd_fire) begin
        rd_cnt_q <= rd_cnt_q + CNT_ONE;
      end

      if (wr_accept) begin
        if (wr_cnt_q != N) begin
          wr_cnt_q <= wr_cnt_q + CNT_ONE;
        end
        if (wr_neg_q) begin
          neg_q <= neg_q + CNT_ONE;
        end
      end

      if (!stall) begin
        // Write stage free (empty or accepting): load the next element.
        wr_en_q    <= src_vld;
        skid_vld_q <= 1'b0;
        if (src_vld) begin
          wr_addr_q <= src_addr;
          wr_data_q <= relu_data;
          wr_neg_q  <= src_neg;
        end
      end else if (flight_q) begin
        skid_vld_q  <= 1'b1;
        skid_data_q <= bus.rd_data;
        skid_addr_q <= flight_addr_q;
      end

      // Placed after the counter updates so a start clear takes priority.
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            neg_q    <= '0;
`ifdef RELU_CLIP_EN
            clip_q   <= clip_val;
`endif
          end
        end
        RUN: begin
          if (rd_fire && (rd_cnt_q == N_LAST)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave on the accepting edge of the last write so done lands in
          // the very next cycle.
          if ((wr_cnt_q == N) || (wr_accept && (wr_cnt_q == N_LAST))) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign neg_count   = neg_q;
  assign bus.rd_en   = rd_fire;
  assign bus.rd_addr = cnt_to_addr(rd_cnt_q);
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_relu_map_ctrl.sv
// -----------------------------------------------------------------------------
// tb_relu_map_ctrl
// Directed bench for relu_map_ctrl. Expected writes are queued when a pass is
// launched; a free-running monitor pops and compares every accepted write and
// also watches the stall rules (held write, no reads while stalled).
// Optional feature macro: RELU_CLIP_EN (adds the clip pass).
// -----------------------------------------------------------------------------
module tb_relu_map_ctrl;
  import relu_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   start;
  logic   busy;
  logic   done;
  cnt_t   neg_count;
`ifdef RELU_CLIP_EN
  value_t clip_val;
`endif

  relu_map_ctrl_if bus();

  relu_map_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef RELU_CLIP_EN
    .clip_val  (clip_val),
`endif
    .busy      (busy),
    .done      (done),
    .neg_count (neg_count),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct packed {
    addr_t  addr;
    value_t data;
  } wr_t;

  wr_t    sb_q[$];
  value_t mem [0:31];
  value_t exp_val [0:31];

  // Input buffer: registered read, data valid one cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end else begin
      $display("check %s = %0h ok", name, got);
    end
  endtask

  // Scoreboard / stall monitor.
  initial begin : monitor
    wr_t    e;
    logic   prev_stall;
    addr_t  prev_addr;
    value_t prev_data;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.wr_en && bus.wr_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL write: unexpected addr=%0d data=%h", bus.wr_addr, bus.wr_data);
          end else begin
            e = sb_q.pop_front();
            if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
              errors++;
              $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                       bus.wr_addr, bus.wr_data, e.addr, e.data);
            end else begin
              $display("write addr=%0d data=%h ok", bus.wr_addr, bus.wr_data);
            end
          end
        end
        if (prev_stall) begin
          checks++;
          if (!bus.wr_en || bus.wr_addr !== prev_addr || bus.wr_data !== prev_data) begin
            errors++;
            $display("FAIL stall_hold: got en=%0b addr=%0d data=%h, expected en=1 addr=%0d data=%h",
                     bus.wr_en, bus.wr_addr, bus.wr_data, prev_addr, prev_data);
          end
        end
        prev_stall = bus.wr_en && !bus.wr_ready;
        if (prev_stall) begin
          checks++;
          if (bus.rd_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_rd_en: got rd_en=%0b, expected 0", bus.rd_en);
          end
        end
        prev_addr = bus.wr_addr;
        prev_data = bus.wr_data;
      end
    end
  end

  // Memory image: 0..24, then overrides. exp_val holds the hand-derived result.
  task automatic base_map();
    for (int i = 0; i < 32; i++) begin
      mem[i]     = value_t'(i);
      exp_val[i] = value_t'(i);
    end
    mem[3]  = 16'hFFF9;  exp_val[3]  = 16'h0000;
    mem[10] = 16'h8000;  exp_val[10] = 16'h0000;
`ifdef RELU_CLIP_EN
    clip_val = 16'hFFFF;  // no element exceeds it: plain ReLU
`endif
  endtask

  task automatic queue_expect();
    for (int i = 0; i < 25; i++) sb_q.push_back({addr_t'(i), exp_val[i]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      {31'd0, busy}, 32'd0);
    check({tag, "_done"},      {31'd0, done}, 32'd0);
    check({tag, "_rd_en"},     {31'd0, bus.rd_en}, 32'd0);
    check({tag, "_rd_addr"},   32'(bus.rd_addr), 32'd0);
    check({tag, "_wr_en"},     {31'd0, bus.wr_en}, 32'd0);
    check({tag, "_wr_addr"},   32'(bus.wr_addr), 32'd0);
    check({tag, "_wr_data"},   32'(bus.wr_data), 32'd0);
    check({tag, "_neg_count"}, 32'(neg_count), 32'd0);
  endtask

  // mode: 0 ready high, 1 ready low in cycles 4..8, 2 ready on odd cycles.
  // x1/x2: extra start pulses (pass cycle numbers). abort_c: cycle to pull rst_n.
  task automatic run_pass(input string tag, input int mode, input int x1, input int x2,
                          input int abort_c, input int exp_done, input int exp_neg);
    int  done_c;
    int  done_before;
    bit  busy_ok;
    done_before = done_cnt;
    done_c  = -1;
    busy_ok = 1'b1;
    queue_expect();
    @(posedge clk); #1;
    start = 1'b1;
    bus.wr_ready = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      start = (c == x1) || (c == x2);
      case (mode)
        1:       bus.wr_ready = !(c >= 4 && c <= 8);
        2:       bus.wr_ready = (c % 2) == 1;
        default: bus.wr_ready = 1'b1;
      endcase
      if (c == abort_c) rst_n = 1'b0;
      @(negedge clk);
      if (c == abort_c) begin
        done_c = c;
        break;
      end
      if (done) begin
        done_c = c;
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    bus.wr_ready = 1'b1;
    if (abort_c > 0) begin
      check_all_zero({tag, "_abort"});
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      sb_q.delete();
      repeat (4) @(negedge clk);
      check({tag, "_abort_no_done"}, 32'(done_cnt - done_before), 32'd0);
      check({tag, "_abort_idle"}, {31'd0, busy}, 32'd0);
    end else begin
      check({tag, "_done_seen"}, {31'd0, done_c != -1}, 32'd1);
      if (exp_done > 0) check({tag, "_done_cycle"}, 32'(done_c), 32'(exp_done));
      check({tag, "_busy_continuous"}, {31'd0, busy_ok}, 32'd1);
      repeat (4) @(negedge clk);
      check({tag, "_done_pulses"}, 32'(done_cnt - done_before), 32'd1);
      check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
      check({tag, "_neg_count"}, 32'(neg_count), 32'(exp_neg));
      check({tag, "_all_written"}, 32'(sb_q.size()), 32'd0);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.wr_ready = 1'b1;
    base_map();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic pass: negatives at 3 and 10, done 28 cycles after start.
    base_map();
    run_pass("basic", 0, -1, -1, 0, 28, 2);

    // Back-pressure window cycles 4..8 delays the pass by 5 cycles.
    run_pass("stall", 1, -1, -1, 0, 33, 2);

    // Ready toggling every cycle, different data and sign extremes.
    for (int i = 0; i < 25; i++) begin
      mem[i]     = value_t'(i * 100);
      exp_val[i] = value_t'(i * 100);
    end
    mem[0]  = 16'hFFFF;  exp_val[0]  = 16'h0000;
    mem[12] = 16'h7FFF;  exp_val[12] = 16'h7FFF;
    mem[24] = 16'h8001;  exp_val[24] = 16'h0000;
    run_pass("toggle", 2, -1, -1, 0, 0, 2);

    // Extra start pulses while busy and in the DONE cycle are ignored.
    base_map();
    run_pass("restart", 0, 5, 28, 0, 28, 2);

    // Reset mid-pass, then a clean pass with a fresh neg_count.
    run_pass("abort", 0, -1, -1, 12, 0, 0);
    mem[20] = 16'hFFFF;  exp_val[20] = 16'h0000;
    run_pass("after_abort", 0, -1, -1, 0, 28, 3);

`ifdef RELU_CLIP_EN
    // Clip at 6: {-1,3,6,7,32767} -> {0,3,6,6,6}; indices 7..24 clip to 6.
    base_map();
    clip_val = 16'd6;
    mem[0] = 16'hFFFF;  exp_val[0] = 16'd0;
    mem[1] = 16'd3;     exp_val[1] = 16'd3;
    mem[2] = 16'd6;     exp_val[2] = 16'd6;
    mem[3] = 16'd7;     exp_val[3] = 16'd6;
    mem[4] = 16'h7FFF;  exp_val[4] = 16'd6;
    mem[5] = 16'd5;     exp_val[5] = 16'd5;
    mem[6] = 16'd6;     exp_val[6] = 16'd6;
    for (int i = 7; i < 25; i++) exp_val[i] = 16'd6;
    exp_val[10] = 16'd0;
    run_pass("clip", 0, -1, -1, 0, 28, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
